lsu_mem_if: RTL and testbench
=============================

Name: lsu_mem_if

Overview:
- Parametrised load/store unit placed between the EX/MEM pipeline stages and the data memory.
- Replaces the fixed 11-bit, single-cycle data path with a handshaked memory interface of configurable address width that tolerates wait states.
- Generates address-shifted byte-lane masks and lane-aligned store data.
- Aligns and sign/zero-extends load data, and reports misaligned accesses.
- Drives busy_o so the hazard logic stalls the pipe while an access is outstanding.

Parameters:
ADDR_W, 11, data address width in bits (minimum 3)
TIMEOUT_CYC, 16, cycles in WAIT before abort (used only with LSU_TIMEOUT_EN; minimum 1)

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  asynchronous active-low reset
req_valid_i  input  1  access request from EX, sampled only in IDLE
req_we_i  input  1  1=store, 0=load
req_size_i  input  2  00 byte, 01 half, 10/11 word
req_signed_i  input  1  1=sign-extend load result
req_addr_i  input  ADDR_W  byte address
req_wdata_i  input  32  store data, right-justified
req_rd_i  input  5  load destination register
busy_o  output  1  access outstanding; stall request
rsp_valid_o  output  1  one-cycle pulse: load result valid
rsp_rdata_o  output  32  aligned, extended load data
rsp_rd_o  output  5  destination register of rsp_rdata_o
err_o  output  1  one-cycle error pulse
err_cause_o  output  2  1 load misaligned, 2 store misaligned, 3 timeout; 0 otherwise
mem_req_o  output  1  memory request, held until ack
mem_wen_o  output  1  active-low write enable
mem_wmask_o  output  4  byte-lane write mask
mem_addr_o  output  ADDR_W  word address (bits [1:0] forced to 0)
mem_wdata_o  output  32  lane-shifted store data
mem_rdata_i  input  32  memory read word
mem_ack_i  input  1  memory completes the request this cycle

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is asynchronous and active-low.
- Reset values:
  - FSM to IDLE; timeout counter 0.
  - mem_req_o 0, mem_wen_o 1, mem_wmask_o 0, mem_addr_o 0, mem_wdata_o 0.
  - rsp_valid_o 0, rsp_rdata_o 0, rsp_rd_o 0, err_o 0, err_cause_o 0, busy_o 0.
  - A reset asserted during WAIT aborts the access. No response and no error are produced.
- FSM states: IDLE, WAIT.
- IDLE + req_valid_i, misaligned (half with addr[0]=1, or word with addr[1:0]≠0):
  - Next cycle: err_o=1, err_cause_o=1 (load) or 2 (store) for one cycle.
  - No memory request is issued. FSM stays in IDLE.
- IDLE + req_valid_i, aligned: register the request and go to WAIT. Next cycle:
  - mem_req_o=1, mem_addr_o={addr[ADDR_W-1:2],2'b00}.
  - Store: mem_wen_o=0.
    - Byte: mask 0001<<addr[1:0], wdata = byte replicated to all 4 lanes.
    - Half: mask 0011<<(2*addr[1]), wdata = halfword replicated to both halves.
    - Word: mask 1111, wdata unchanged.
  - Load: mem_wen_o=1, mask 0000.
- WAIT:
  - busy_o=1. mem_* outputs are held stable. req_valid_i is ignored.
  - When mem_ack_i=1, drop mem_req_o, restore mem_wen_o=1 and mask 0 next cycle, and return to IDLE.
  - Load completion: in the same next cycle, rsp_valid_o=1 and rsp_rd_o=registered rd. rsp_rdata_o is:
    - byte: mem_rdata_i[8*addr[1:0]+:8]
    - half: mem_rdata_i[16*addr[1]+:16]
    - word: full mem_rdata_i
    - byte/half results are sign- or zero-extended per req_signed_i.
  - Store completion produces no rsp_valid_o.
- busy_o timing:
  - Rises the cycle after acceptance. Falls the cycle after ack.
  - Minimum access latency is 2 cycles (accept → request → response with ack on the first request cycle).
- rsp_rdata_o and rsp_rd_o hold their value until the next load completes.
- mem_ack_i outside WAIT is ignored.
- Back-to-back: a new request may be accepted in the first IDLE cycle after completion.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the counter reaches TIMEOUT_CYC with no ack: next cycle mem_req_o=0, err_o=1, err_cause_o=3, FSM to IDLE, no rsp_valid_o.
  - Ack in the same cycle as the count reaching TIMEOUT_CYC: ack wins and the access completes normally.
- Not defined: no counter; WAIT persists until mem_ack_i. TIMEOUT_CYC is unused.

Test Plan:
- Load byte, signed, addr=0x103, mem_rdata_i=0x80112233, ack on first request cycle:
  - mem_addr_o=0x100.
  - Next cycle: rsp_valid_o=1, rsp_rdata_o=0xFFFFFF80, rsp_rd_o=req_rd_i.
  - Total latency 2 cycles.
- Store half, addr=0x006, wdata=0x0000ABCD, ack after 3 wait cycles:
  - mem_wmask_o=1100, mem_wdata_o=0xABCDABCD, mem_wen_o=0 held 4 cycles.
  - busy_o high 4 cycles; no rsp_valid_o.
- Load word at addr=0x002:
  - err_o=1, err_cause_o=1 for one cycle.
  - mem_req_o never asserts; busy_o stays 0.
- With LSU_TIMEOUT_EN, TIMEOUT_CYC=4, no ack: after 4 WAIT cycles, err_cause_o=3, mem_req_o=0, FSM back to IDLE.
- reset_i low during WAIT of a load:
  - All outputs go to reset values immediately (asynchronously).
  - No rsp_valid_o or err_o after release.
- Load half unsigned, addr=0x00A, mem_rdata_i=0x9ABC1234, immediately followed by a byte store:
  - rsp_rdata_o=0x00009ABC.
  - Store accepted on the first IDLE cycle; mem_wmask_o shifted correctly.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Load/store unit bridging EX/MEM to a handshaked data memory with wait states.
// Optional access timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_if #(
    parameter int ADDR_W      = 11,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              busy_o,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic [4:0]        rsp_rd_o,
    output logic              err_o,
    output logic [1:0]        err_cause_o,
    output logic              mem_req_o,
    output logic              mem_wen_o,
    output logic [3:0]        mem_wmask_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i
);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    if (ADDR_W < 3 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("lsu_mem_if: ADDR_W must be >= 3 and TIMEOUT_CYC >= 1");
    end

    // Select the addressed byte/half lane and extend it to 32 bits.
    function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_align = {{24{sgn & b[7]}}, b};
            2'b01:   load_align = {{16{sgn & h[15]}}, h};
            default: load_align = word;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic              busy_q, busy_d, rsp_valid_q, rsp_valid_d, err_q, err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d, mem_wdata_q, mem_wdata_d;
    logic [4:0]        rsp_rd_q, rsp_rd_d, rd_q, rd_d;
    logic [1:0]        err_cause_q, err_cause_d, size_q, size_d, lane_q, lane_d;
    logic              mem_req_q, mem_req_d, mem_wen_q, mem_wen_d, we_q, we_d, sgn_q, sgn_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              misaligned_s, timeout_s;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Abort fires on the WAIT cycle in which the count would reach TIMEOUT_CYC.
    assign timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_s = 1'b0;
`endif

    assign misaligned_s = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                          (req_size_i[1] && (req_addr_i[1:0] != 2'b00));

    // Next-state and next-output computation.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_rd_d    = rsp_rd_q;
        err_d       = 1'b0;
        err_cause_d = 2'd0;
        mem_req_d   = mem_req_q;
        mem_wen_d   = mem_wen_q;
        mem_wmask_d = mem_wmask_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        we_d        = we_q;
        sgn_d       = sgn_q;
        size_d      = size_q;
        lane_d      = lane_q;
        rd_d        = rd_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i && misaligned_s) begin
                    err_d       = 1'b1;
                    err_cause_d = req_we_i ? 2'd2 : 2'd1;
                end else if (req_valid_i) begin
                    state_d     = WAIT;
                    busy_d      = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_wen_d   = ~req_we_i;
                    mem_addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
                    we_d        = req_we_i;
                    sgn_d       = req_signed_i;
                    size_d      = req_size_i;
                    lane_d      = req_addr_i[1:0];
                    rd_d        = req_rd_i;
`ifdef LSU_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                    case (req_size_i)
                        2'b00: begin
                            mem_wmask_d = 4'b0001 << req_addr_i[1:0];
                            mem_wdata_d = {4{req_wdata_i[7:0]}};
                        end
                        2'b01: begin
                            mem_wmask_d = req_addr_i[1] ? 4'b1100 : 4'b0011;
                            mem_wdata_d = {2{req_wdata_i[15:0]}};
                        end
                        default: begin
                            mem_wmask_d = 4'b1111;
                            mem_wdata_d = req_wdata_i;
                        end
                    endcase
                    if (!req_we_i) begin
                        mem_wmask_d = 4'b0000;
                    end else begin
                        mem_wmask_d = mem_wmask_d;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (mem_ack_i || timeout_s) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    mem_req_d   = 1'b0;
                    mem_wen_d   = 1'b1;
                    mem_wmask_d = 4'b0000;
                    if (mem_ack_i && !we_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = load_align(mem_rdata_i, size_q, lane_q, sgn_q);
                        rsp_rd_d    = rd_q;
                    end else if (!mem_ack_i) begin
                        err_d       = 1'b1;
                        err_cause_d = 2'd3;
                    end else begin
                        rsp_valid_d = 1'b0;
                    end
                end else begin
`ifdef LSU_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any outstanding access.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_rd_q    <= 5'd0;
            err_q       <= 1'b0;
            err_cause_q <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_wen_q   <= 1'b1;
            mem_wmask_q <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= 2'd0;
            lane_q      <= 2'd0;
            rd_q        <= 5'd0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_rd_q    <= rsp_rd_d;
            err_q       <= err_d;
            err_cause_q <= err_cause_d;
            mem_req_q   <= mem_req_d;
            mem_wen_q   <= mem_wen_d;
            mem_wmask_q <= mem_wmask_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            we_q        <= we_d;
            sgn_q       <= sgn_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            rd_q        <= rd_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_rd_o    = rsp_rd_q;
    assign err_o       = err_q;
    assign err_cause_o = err_cause_q;
    assign mem_req_o   = mem_req_q;
    assign mem_wen_o   = mem_wen_q;
    assign mem_wmask_o = mem_wmask_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed self-checking bench for lsu_mem_if; timeout steps run when LSU_TIMEOUT_EN is defined.
module tb_lsu_mem_if;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i, req_we_i, req_signed_i, mem_ack_i;
    logic [1:0]  req_size_i;
    logic [10:0] req_addr_i;
    logic [31:0] req_wdata_i, mem_rdata_i;
    logic [4:0]  req_rd_i;
    logic        busy_o, rsp_valid_o, err_o, mem_req_o, mem_wen_o;
    logic [31:0] rsp_rdata_o, mem_wdata_o;
    logic [4:0]  rsp_rd_o;
    logic [1:0]  err_cause_o;
    logic [3:0]  mem_wmask_o;
    logic [10:0] mem_addr_o;
    int checks = 0;
    int errors = 0;

    lsu_mem_if #(.ADDR_W(11), .TIMEOUT_CYC(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .req_valid_i(req_valid_i), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i), .busy_o(busy_o),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_rd_o(rsp_rd_o),
        .err_o(err_o), .err_cause_o(err_cause_o), .mem_req_o(mem_req_o),
        .mem_wen_o(mem_wen_o), .mem_wmask_o(mem_wmask_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [10:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_signed_i = sgn;
        req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
    endtask

    initial begin
        reset_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
        req_signed_i = 1'b0; req_addr_i = 11'd0; req_wdata_i = 32'd0; req_rd_i = 5'd0;
        mem_rdata_i = 32'd0; mem_ack_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_wen", {31'd0, mem_wen_o}, 32'd1);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'h0);
        reset_i = 1'b1;
        @(negedge clk_i);

        // ack while idle is ignored
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        chk("idle_ack_rsp", {31'd0, rsp_valid_o}, 32'd0);
        mem_ack_i = 1'b0;

        // signed byte load at 0x103, ack on first request cycle
        req(1'b0, 2'b00, 1'b1, 11'h103, 32'h0, 5'd5);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("lb_req", {31'd0, mem_req_o}, 32'd1);
        chk("lb_busy", {31'd0, busy_o}, 32'd1);
        chk("lb_addr", {21'd0, mem_addr_o}, 32'h100);
        chk("lb_wen", {31'd0, mem_wen_o}, 32'd1);
        chk("lb_mask", {28'd0, mem_wmask_o}, 32'h0);
        mem_rdata_i = 32'h8011_2233; mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk("lb_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("lb_data", rsp_rdata_o, 32'hFFFF_FF80);
        chk("lb_rd", {27'd0, rsp_rd_o}, 32'd5);
        chk("lb_busy_fall", {31'd0, busy_o}, 32'd0);
        chk("lb_req_fall", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk_i);
        chk("lb_pulse", {31'd0, rsp_valid_o}, 32'd0);

        // half store at 0x006, ack after three wait cycles; a misaligned request in WAIT is ignored
        req(1'b1, 2'b01, 1'b0, 11'h006, 32'h0000_ABCD, 5'd0);
        @(negedge clk_i);
        req(1'b0, 2'b10, 1'b0, 11'h001, 32'h0, 5'd9);
        for (int i = 0; i < 4; i++) begin
            chk("sh_wen", {31'd0, mem_wen_o}, 32'd0);
            chk("sh_mask", {28'd0, mem_wmask_o}, 32'hC);
            chk("sh_wdata", mem_wdata_o, 32'hABCD_ABCD);
            chk("sh_addr", {21'd0, mem_addr_o}, 32'h004);
            chk("sh_busy", {31'd0, busy_o}, 32'd1);
            chk("sh_err", {31'd0, err_o}, 32'd0);
            chk("sh_rsp", {31'd0, rsp_valid_o}, 32'd0);
            if (i == 3) begin
                mem_ack_i = 1'b1; req_valid_i = 1'b0;
            end
            @(negedge clk_i);
        end
        mem_ack_i = 1'b0;
        chk("sh_done_busy", {31'd0, busy_o}, 32'd0);
        chk("sh_done_rsp", {31'd0, rsp_valid_o}, 32'd0);
        chk("sh_done_wen", {31'd0, mem_wen_o}, 32'd1);
        chk("sh_done_mask", {28'd0, mem_wmask_o}, 32'h0);
        chk("rdata_hold", rsp_rdata_o, 32'hFFFF_FF80);

        // misaligned word load and misaligned half store
        req(1'b0, 2'b10, 1'b0, 11'h002, 32'h0, 5'd3);
        @(negedge clk_i);
        req(1'b1, 2'b01, 1'b0, 11'h001, 32'h0, 5'd0);
        chk("lw_mis_err", {31'd0, err_o}, 32'd1);
        chk("lw_mis_cause", {30'd0, err_cause_o}, 32'd1);
        chk("lw_mis_req", {31'd0, mem_req_o}, 32'd0);
        chk("lw_mis_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("sh_mis_cause", {30'd0, err_cause_o}, 32'd2);
        chk("sh_mis_req", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk_i);
        chk("mis_err_pulse", {31'd0, err_o}, 32'd0);
        chk("mis_cause_clr", {30'd0, err_cause_o}, 32'd0);

        // unsigned half load at 0x00A, then byte store on the first IDLE cycle
        req(1'b0, 2'b01, 1'b0, 11'h00A, 32'h0, 5'd12);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        mem_rdata_i = 32'h9ABC_1234; mem_ack_i = 1'b1;
        @(negedge clk_i);
        chk("lhu_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("lhu_data", rsp_rdata_o, 32'h0000_9ABC);
        chk("lhu_rd", {27'd0, rsp_rd_o}, 32'd12);
        req(1'b1, 2'b00, 1'b0, 11'h00D, 32'h0000_005A, 5'd0);
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("sb_req", {31'd0, mem_req_o}, 32'd1);
        chk("sb_mask", {28'd0, mem_wmask_o}, 32'h2);
        chk("sb_wdata", mem_wdata_o, 32'h5A5A_5A5A);
        chk("sb_addr", {21'd0, mem_addr_o}, 32'h00C);
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk("sb_done_busy", {31'd0, busy_o}, 32'd0);

        // signed half load lower lane
        req(1'b0, 2'b01, 1'b1, 11'h008, 32'h0, 5'd7);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        mem_rdata_i = 32'h9ABC_8001; mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk("lh_data", rsp_rdata_o, 32'hFFFF_8001);

`ifdef LSU_TIMEOUT_EN
        // no ack: abort after four WAIT cycles
        req(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 5'd4);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("to_wait_req", {31'd0, mem_req_o}, 32'd1);
            chk("to_wait_err", {31'd0, err_o}, 32'd0);
            @(negedge clk_i);
        end
        chk("to_err", {31'd0, err_o}, 32'd1);
        chk("to_cause", {30'd0, err_cause_o}, 32'd3);
        chk("to_req", {31'd0, mem_req_o}, 32'd0);
        chk("to_busy", {31'd0, busy_o}, 32'd0);
        chk("to_rsp", {31'd0, rsp_valid_o}, 32'd0);
        @(negedge clk_i);
`endif

        // asynchronous reset during WAIT of a load
        req(1'b0, 2'b10, 1'b0, 11'h020, 32'h0, 5'd6);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("ar_req_before", {31'd0, mem_req_o}, 32'd1);
        #2 reset_i = 1'b0;
        #1;
        chk("ar_req", {31'd0, mem_req_o}, 32'd0);
        chk("ar_busy", {31'd0, busy_o}, 32'd0);
        chk("ar_wen", {31'd0, mem_wen_o}, 32'd1);
        chk("ar_rdata", rsp_rdata_o, 32'h0);
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            chk("ar_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
            chk("ar_no_err", {31'd0, err_o}, 32'd0);
        end
        mem_ack_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
